// File: rtl/ctrl_decode_idex_if.sv
// ID/EX control bundle: ID-stage instruction fields in, registered EX control word, RtEx and Stall out.
// Master drives the instruction side; slave is the decode/hazard block.
interface ctrl_decode_idex_if;
  logic [5:0] Opcode;
  logic [4:0] Rs;
  logic [4:0] Rt;
  logic       Valid;
  logic       Flush;
  logic [9:0] Control;
  logic [4:0] RtEx;
  logic       Stall;

  modport master (
    output Opcode, Rs, Rt, Valid, Flush,
    input  Control, RtEx, Stall
  );

  modport slave (
    input  Opcode, Rs, Rt, Valid, Flush,
    output Control, RtEx, Stall
  );
endinterface

// File: rtl/ctrl_decode_idex.sv
// ID/EX decode register with load-use bubble and two-edge flush; Control/RtEx latency 1 cycle, Stall combinational.
// Stall holds PC and IF/ID for one cycle; load-use detection only when HAZARD_DETECT_EN is defined.
module ctrl_decode_idex (
  input  logic              clk,
  input  logic              reset,
  ctrl_decode_idex_if.slave bus
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_BUBBLE = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [1:0] state_q, state_d;
  logic [9:0] control_q, control_d;
  logic [4:0] rt_ex_q, rt_ex_d;
  logic [9:0] dec_word;
  logic       load_use;

  always_comb begin
    dec_word = 10'h000;
    case (bus.Opcode)
      OP_RTYPE: dec_word = 10'h122;
      OP_LW:    dec_word = 10'h0F0;
      OP_SW:    dec_word = 10'h088;
      OP_BEQ:   dec_word = 10'h005;
      OP_J:     dec_word = 10'h200;
      OP_ADDI:  dec_word = 10'h0A0;
      default:  dec_word = 10'h000;
    endcase
  end

`ifdef HAZARD_DETECT_EN
  // Rt is only a true source for R-type, sw and beq; elsewhere it is a destination.
  always_comb begin
    load_use = 1'b0;
    if (state_q == ST_RUN && bus.Valid && !bus.Flush &&
        control_q[4] && rt_ex_q != 5'd0) begin
      if (rt_ex_q == bus.Rs) begin
        load_use = 1'b1;
      end else if (rt_ex_q == bus.Rt &&
                   (bus.Opcode == OP_RTYPE || bus.Opcode == OP_SW ||
                    bus.Opcode == OP_BEQ)) begin
        load_use = 1'b1;
      end
    end
  end
`else
  logic unused_hazard_inputs;
  assign unused_hazard_inputs = ^bus.Rs;
  assign load_use = 1'b0;
`endif

  always_comb begin
    state_d   = ST_RUN;
    control_d = 10'h000;
    rt_ex_d   = 5'd0;
    if (bus.Flush) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_FLUSH: begin
          state_d = ST_RUN;
        end
        ST_BUBBLE: begin
          state_d = ST_RUN;
          if (bus.Valid) begin
            control_d = dec_word;
            rt_ex_d   = bus.Rt;
          end
        end
        default: begin
          if (load_use) begin
            state_d = ST_BUBBLE;
          end else if (bus.Valid) begin
            control_d = dec_word;
            rt_ex_d   = bus.Rt;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      control_q <= 10'h000;
      rt_ex_q   <= 5'd0;
    end else begin
      state_q   <= state_d;
      control_q <= control_d;
      rt_ex_q   <= rt_ex_d;
    end
  end

  assign bus.Control = control_q;
  assign bus.RtEx    = rt_ex_q;
  assign bus.Stall   = load_use;

endmodule
